muldiv_unit: RTL

- Iterative RV32M multiply/divide execute unit.
- Sits between the register file read ports (rd1/rd2 feed a/b) and its write port. result and rd_out drive wd and rd, and done drives reg_write.
- While busy is high, the core stalls PC and instruction fetch. Shared shift-add/restoring datapath, fixed latency.

---
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/muldiv_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// Handshake and data bundle between the issuing core and the RV32M multiply/divide unit.
// The core (master) drives the request fields; the unit (slave) returns status and writeback data.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, op, a, b, rd_in,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, op, a, b, rd_in,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shared shift-add / restoring-divide step per cycle,
// fixed 32-iteration latency for every op; operands are reduced to magnitudes on acceptance.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave mdu
);
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic [4:0]       rd_q;
    logic [XLEN-1:0]  hi;
    logic [XLEN-1:0]  lo;
    logic [XLEN-1:0]  opb;
    logic             neg_p;
    logic             neg_q;
    logic             neg_r;
    logic             busy_q;
    logic             done_q;
    logic [XLEN-1:0]  result_q;
    logic [4:0]       rd_out_q;

    function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v, input logic neg);
        logic signed [XLEN-1:0] m;
        m = neg ? -v : v;
        return $unsigned(m);
    endfunction

    // Reapplies operand signs to the unsigned product / quotient / remainder and picks the word.
    function automatic logic [XLEN-1:0] finalize(input logic [2:0] f, input logic [XLEN-1:0] h,
                                                 input logic [XLEN-1:0] l, input logic np,
                                                 input logic nq, input logic nr);
        logic signed [2*XLEN-1:0] prod;
        logic signed [XLEN-1:0]   quo;
        logic signed [XLEN-1:0]   rem;
        prod = {h, l};
        quo  = l;
        rem  = h;
        if (np) prod = -prod;
        if (nq) quo = -quo;
        if (nr) rem = -rem;
        case (f)
            OP_MUL:                       return prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: return prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              return $unsigned(quo);
            default:                      return $unsigned(rem);
        endcase
    endfunction

    logic                   a_signed_op;
    logic                   b_signed_op;
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic                   a_neg;
    logic                   b_neg;

    always_comb begin
        a_s         = mdu.a;
        b_s         = mdu.b;
        a_signed_op = (mdu.op == OP_MULH) || (mdu.op == OP_MULHSU) ||
                      (mdu.op == OP_DIV)  || (mdu.op == OP_REM);
        b_signed_op = (mdu.op == OP_MULH) || (mdu.op == OP_DIV) || (mdu.op == OP_REM);
        a_neg       = a_signed_op && (a_s < 0);
        b_neg       = b_signed_op && (b_s < 0);
    end

    // hi:lo is the product for multiplies and remainder:quotient for divides.
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shl;
    logic [XLEN-1:0] diff;
    logic            ge;
    logic [XLEN-1:0] hi_nxt;
    logic [XLEN-1:0] lo_nxt;

    always_comb begin
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
        shl  = {hi, lo[XLEN-1]};
        diff = shl[XLEN-1:0] - opb;
        ge   = shl >= {1'b0, opb};
        if (op_q[2]) begin
            hi_nxt = ge ? diff : shl[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], ge};
        end else begin
            hi_nxt = sum[XLEN:1];
            lo_nxt = {sum[0], lo[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (mdu.start) begin
                        op_q   <= mdu.op;
                        rd_q   <= mdu.rd_in;
                        hi     <= '0;
                        lo     <= magnitude(a_s, a_neg);
                        opb    <= magnitude(b_s, b_neg);
                        neg_p  <= a_neg ^ b_neg;
                        // A zero divisor keeps the all-ones quotient unsigned.
                        neg_q  <= (a_neg ^ b_neg) && (mdu.b != '0);
                        neg_r  <= a_neg;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= CALC;
                    end else begin
                        state  <= IDLE;
                    end
                end
                CALC: begin
                    hi  <= hi_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN - 1)) begin
                        result_q <= finalize(op_q, hi_nxt, lo_nxt, neg_p, neg_q, neg_r);
                        rd_out_q <= rd_q;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= DONE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign mdu.busy   = busy_q;
    assign mdu.done   = done_q;
    assign mdu.result = result_q;
    assign mdu.rd_out = rd_out_q;
endmodule
